// File: rtl/irq_capture_pkg.sv
`default_nettype none
// irq_capture_pkg: shared widths and vector/index types for the request-capture stage.
// Rev 1.0
package irq_capture_pkg;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  typedef logic [WIDTH-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;
endpackage
`default_nettype wire

// File: rtl/sync_2ff_v.sv
`default_nettype none
// sync_2ff_v: vector-wide two-flop synchronizer, both stages async-reset to 0.
// Rev 1.0
module sync_2ff_v #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/irq_request_capture_v.sv
`default_nettype none
// irq_request_capture_v: rising-edge request capture into ack-cleared pending bits with
// sticky lost flags. Optional input synchronizer: IRQ_CAPTURE_SYNC_EN. Rev 1.0
module irq_request_capture_v
  import irq_capture_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_req,
  input  logic [WIDTH-1:0] i_mask,
  input  logic             i_ack,
  input  logic [IDX_W-1:0] i_ack_idx,
  input  logic             i_lost_clr,
  output logic [WIDTH-1:0] o_pending,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_lost
);
  req_vec_t w_sync;
  req_vec_t w_edge;
  req_vec_t w_ack_vec;
  req_vec_t w_pend_nxt;
  req_vec_t w_lost_evt;
  req_vec_t r_prev;
  req_vec_t r_pending;
  req_vec_t r_lost;
  logic     r_valid;

`ifdef IRQ_CAPTURE_SYNC_EN
  sync_2ff_v #(
    .W (WIDTH)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_req),
    .o_q     (w_sync)
  );
`else
  assign w_sync = i_req;
`endif

  always_comb begin
    w_ack_vec = '0;
    if (i_ack) w_ack_vec[i_ack_idx] = 1'b1;
  end

  // prev tracks sync regardless of mask, so unmasking a held-high line is not an event
  assign w_edge     = w_sync & ~r_prev & i_mask;
  assign w_pend_nxt = w_edge | (r_pending & ~w_ack_vec);
  assign w_lost_evt = w_edge & r_pending & ~w_ack_vec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_lost    <= '0;
    end else begin
      r_prev    <= w_sync;
      r_pending <= w_pend_nxt;
      r_valid   <= |w_pend_nxt;
      r_lost    <= (i_lost_clr ? '0 : r_lost) | w_lost_evt;
    end
  end

  assign o_pending = r_pending;
  assign o_valid   = r_valid;
  assign o_lost    = r_lost;
endmodule
`default_nettype wire

// File: tb/tb_irq_request_capture_v.sv
`default_nettype none
// tb_irq_request_capture_v: directed plus randomized checks against a per-line event model.
// Rev 1.0
module tb_irq_request_capture_v;
`ifdef IRQ_CAPTURE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_idx;
  logic       lost_clr;
  logic [7:0] o_pending;
  logic       o_valid;
  logic [7:0] o_lost;

  int checks;
  int failures;

  // model state: what each line is expected to hold
  logic [7:0] m_pend;
  logic [7:0] m_prev;
  logic [7:0] m_lost;
  logic       m_valid;
  logic [7:0] q_req[$];

  irq_request_capture_v dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_mask     (mask),
    .i_ack      (ack),
    .i_ack_idx  (ack_idx),
    .i_lost_clr (lost_clr),
    .o_pending  (o_pending),
    .o_valid    (o_valid),
    .o_lost     (o_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_prev  = '0;
    m_lost  = '0;
    m_valid = 1'b0;
    q_req.delete();
    for (int i = 0; i < LAT - 1; i++) q_req.push_back(8'h00);
  endtask

  // line k sees the request value from LAT-1 edges ago; a new event beats a same-cycle ack
  task automatic model_edge();
    logic [7:0] s;
    logic       ev;
    logic       ak;
    q_req.push_back(req);
    s = q_req.pop_front();
    if (lost_clr) m_lost = '0;
    for (int k = 0; k < 8; k++) begin
      ev = s[k] && !m_prev[k] && mask[k];
      ak = ack && (int'(ack_idx) == k);
      if (ev) begin
        if (m_pend[k] && !ak) m_lost[k] = 1'b1;
        m_pend[k] = 1'b1;
      end else if (ak) begin
        m_pend[k] = 1'b0;
      end
      m_prev[k] = s[k];
    end
    m_valid = (m_pend != 8'h00);
  endtask

  task automatic cyc(input logic [7:0] r, input logic [7:0] m, input logic a,
                     input logic [2:0] ai, input logic lc);
    req = r; mask = m; ack = a; ack_idx = ai; lost_clr = lc;
    @(posedge clk);
    model_edge();
    #1;
    chk("pending", o_pending, m_pend);
    chk("valid", {7'd0, o_valid}, {7'd0, m_valid});
    chk("lost", o_lost, m_lost);
  endtask

  function automatic logic [2:0] highest(input logic [7:0] v);
    logic [2:0] h;
    h = 3'd0;
    for (int k = 0; k < 8; k++) if (v[k]) h = 3'(k);
    return h;
  endfunction

  initial begin
    checks = 0; failures = 0;
    req = '0; mask = 8'hFF; ack = 0; ack_idx = '0; lost_clr = 0; rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pending", o_pending, 8'h00);
    chk("rst_lost", o_lost, 8'h00);
    @(negedge clk);
    rst_n = 1;

    repeat (5) cyc(8'h00, 8'hFF, 0, 0, 0);
    chk("idle_pending", o_pending, 8'h00);

    // two lines rise; ack highest then remaining one
    repeat (LAT) cyc(8'h82, 8'hFF, 0, 0, 0);
    chk("pend82", o_pending, 8'h82);
    cyc(8'h82, 8'hFF, 1, 3'd7, 0);
    chk("ack7", o_pending, 8'h02);
    cyc(8'h82, 8'hFF, 1, 3'd1, 0);
    chk("ack1", o_pending, 8'h00);
    chk("ack1_valid", {7'd0, o_valid}, 8'h00);

    // re-pulse a pending line -> lost flag, then clear it
    repeat (LAT) cyc(8'h10, 8'hFF, 0, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0, 0);
    repeat (LAT) cyc(8'h10, 8'hFF, 0, 0, 0);
    chk("lost_pend", o_pending, 8'h10);
    chk("lost_set", o_lost, 8'h10);
    cyc(8'h10, 8'hFF, 0, 0, 1);
    chk("lost_clr", o_lost, 8'h00);

    // edge on line 2 coinciding with its ack
    repeat (LAT) cyc(8'h14, 8'hFF, 0, 0, 0);
    cyc(8'h10, 8'hFF, 0, 0, 0);
    repeat (LAT - 1) cyc(8'h14, 8'hFF, 0, 0, 0);
    cyc(8'h14, 8'hFF, 1, 3'd2, 0);
    chk("evt_wins_pend", o_pending, 8'h14);
    chk("evt_wins_lost", o_lost, 8'h00);
    cyc(8'h14, 8'hFF, 1, 3'd4, 0);
    cyc(8'h14, 8'hFF, 1, 3'd2, 0);
    cyc(8'h14, 8'hFF, 1, 3'd5, 0);
    chk("ack_empty", o_pending, 8'h00);
    repeat (LAT) cyc(8'h00, 8'hFF, 0, 0, 0);

    // masked edge dropped; unmasking a held-high line is no event
    repeat (LAT + 1) cyc(8'h01, 8'hFE, 0, 0, 0);
    chk("masked", o_pending, 8'h00);
    repeat (LAT + 1) cyc(8'h01, 8'hFF, 0, 0, 0);
    chk("unmask_high", o_pending, 8'h00);
    repeat (LAT) cyc(8'h00, 8'hFF, 0, 0, 0);
    repeat (LAT) cyc(8'h01, 8'hFF, 0, 0, 0);
    chk("reraise", o_pending, 8'h01);
    cyc(8'h01, 8'hFF, 1, 3'd0, 0);

    // async reset mid-operation
    repeat (LAT) cyc(8'h00, 8'hFF, 0, 0, 0);
    repeat (LAT) cyc(8'hC3, 8'hFF, 0, 0, 0);
    chk("pendC3", o_pending, 8'hC3);
    rst_n = 0;
    #2;
    chk("async_pending", o_pending, 8'h00);
    chk("async_valid", {7'd0, o_valid}, 8'h00);
    chk("async_lost", o_lost, 8'h00);
    model_reset();
    req = 8'h01;
    @(negedge clk);
    rst_n = 1;
    repeat (LAT) cyc(8'h01, 8'hFF, 0, 0, 0);
    chk("rst_release_evt", o_pending, 8'h01);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      logic [7:0] m;
      logic       a;
      logic [2:0] ai;
      r  = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      m  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      a  = ($urandom_range(0, 2) == 0);
      ai = (m_pend != 8'h00 && $urandom_range(0, 3) != 0) ? highest(m_pend) : 3'($urandom);
      cyc(r, m, a, ai, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
